// File: rtl/tl_cpl_gen.sv
// Completer-side CplD generator: turns memory-read requests into 3DW completions on a 128-bit TX stream.
// Define TL_CPL_SPLIT_EN to split completions at MPS_DW-aligned DW boundaries (default: one completion per request).
module tl_cpl_gen #(
    parameter int TAG_W  = 8,
    parameter int MPS_DW = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      completer_id_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [TAG_W-1:0] req_tag_i,
    input  logic [15:0]      req_id_i,
    input  logic [31:0]      req_addr_i,
    input  logic [9:0]       req_len_i,
    input  logic [2:0]       req_tc_i,
    input  logic [2:0]       req_attr_i,
    output logic             usr_rd_valid_o,
    input  logic             usr_rd_ready_i,
    output logic [31:0]      usr_rd_addr_o,
    output logic [10:0]      usr_rd_len_o,
    input  logic [127:0]     usr_rd_data_i,
    input  logic             usr_rd_dvalid_i,
    output logic             usr_rd_dready_o,
    output logic [127:0]     tx_data_o,
    output logic             tx_valid_o,
    output logic             tx_sop_o,
    output logic             tx_eop_o,
    input  logic             tx_ready_i
);
    // state | meaning
    // IDLE  | waiting for a read request
    // ISSUE | presenting the user read command for the current chunk
    // HDR   | emitting header beat carrying the first data DW
    // DATA  | emitting data realigned by one DW; last beat may be a drain beat
    // NEXT  | one-cycle gap, then next chunk or back to IDLE
    typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_HDR, ST_DATA, ST_NEXT} state_t;

`ifdef TL_CPL_SPLIT_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif
    localparam int MpsW = $clog2(MPS_DW);

    state_t           state_q, state_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [15:0]      req_id_q, req_id_d;
    logic [2:0]       tc_q, tc_d;
    logic [2:0]       attr_q, attr_d;
    logic [10:0]      rem_dw_q, rem_dw_d;
    logic [31:0]      cur_addr_q, cur_addr_d;
    logic [95:0]      buf_q, buf_d;
    logic [9:0]       out_left_q, out_left_d;

    logic [10:0] room;
    logic [10:0] chunk;
    logic [7:0]  tag8;
    logic [31:0] hdr_dw0, hdr_dw1, hdr_dw2;
    logic [95:0] drain_mask;
    logic        use_usr;
    logic        fire;
    logic        last_beat;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr_i[1:0];

    // Room left before the next MPS_DW-aligned DW address bounds the chunk when splitting.
    assign room  = 11'(MPS_DW) - 11'(cur_addr_q[2 +: MpsW]);
    assign chunk = (SplitEn && (room < rem_dw_q)) ? room : rem_dw_q;

    assign tag8    = 8'(tag_q);
    assign hdr_dw0 = {3'b010, 5'b01010, 1'b0, tc_q, 1'b0, attr_q[2], 4'b0000,
                      attr_q[1:0], 2'b00, chunk[9:0]};
    assign hdr_dw1 = {completer_id_i, 3'b000, 1'b0, rem_dw_q[9:0], 2'b00};
    assign hdr_dw2 = {req_id_q, tag8, 1'b0, cur_addr_q[6:0]};

    assign use_usr    = (out_left_q > 10'd3);
    assign drain_mask = {{32{out_left_q > 10'd2}}, {32{out_left_q > 10'd1}}, 32'hFFFF_FFFF};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tag_q      <= '0;
            req_id_q   <= '0;
            tc_q       <= '0;
            attr_q     <= '0;
            rem_dw_q   <= '0;
            cur_addr_q <= '0;
            buf_q      <= '0;
            out_left_q <= '0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            req_id_q   <= req_id_d;
            tc_q       <= tc_d;
            attr_q     <= attr_d;
            rem_dw_q   <= rem_dw_d;
            cur_addr_q <= cur_addr_d;
            buf_q      <= buf_d;
            out_left_q <= out_left_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        tag_d           = tag_q;
        req_id_d        = req_id_q;
        tc_d            = tc_q;
        attr_d          = attr_q;
        rem_dw_d        = rem_dw_q;
        cur_addr_d      = cur_addr_q;
        buf_d           = buf_q;
        out_left_d      = out_left_q;
        req_ready_o     = 1'b0;
        usr_rd_valid_o  = 1'b0;
        usr_rd_addr_o   = '0;
        usr_rd_len_o    = '0;
        usr_rd_dready_o = 1'b0;
        tx_data_o       = '0;
        tx_valid_o      = 1'b0;
        tx_sop_o        = 1'b0;
        tx_eop_o        = 1'b0;
        fire            = 1'b0;
        last_beat       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    tag_d      = req_tag_i;
                    req_id_d   = req_id_i;
                    tc_d       = req_tc_i;
                    attr_d     = req_attr_i;
                    rem_dw_d   = (req_len_i == 10'd0) ? 11'd1024 : {1'b0, req_len_i};
                    cur_addr_d = {req_addr_i[31:2], 2'b00};
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                usr_rd_valid_o = 1'b1;
                usr_rd_addr_o  = cur_addr_q;
                usr_rd_len_o   = chunk;
                if (usr_rd_ready_i) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                tx_valid_o      = usr_rd_dvalid_i;
                tx_sop_o        = 1'b1;
                tx_eop_o        = (chunk == 11'd1);
                usr_rd_dready_o = tx_ready_i;
                tx_data_o       = {usr_rd_data_i[31:0], hdr_dw2, hdr_dw1, hdr_dw0};
                fire            = tx_valid_o && tx_ready_i;
                if (fire) begin
                    buf_d      = usr_rd_data_i[127:32];
                    out_left_d = 10'(chunk - 11'd1);
                    if (chunk == 11'd1) begin
                        last_beat = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // With three or fewer DWs left the buffer alone finishes the chunk.
                if (use_usr) begin
                    tx_valid_o      = usr_rd_dvalid_i;
                    usr_rd_dready_o = tx_ready_i;
                    tx_data_o       = {usr_rd_data_i[31:0], buf_q};
                end else begin
                    tx_valid_o = 1'b1;
                    tx_data_o  = {32'h0, buf_q & drain_mask};
                end
                tx_eop_o = (out_left_q <= 10'd4);
                fire     = tx_valid_o && tx_ready_i;
                if (fire) begin
                    if (use_usr) begin
                        buf_d = usr_rd_data_i[127:32];
                    end
                    if (tx_eop_o) begin
                        last_beat = 1'b1;
                    end else begin
                        out_left_d = out_left_q - 10'd4;
                    end
                end
            end
            ST_NEXT: begin
                state_d = (rem_dw_q == 11'd0) ? ST_IDLE : ST_ISSUE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (last_beat) begin
            rem_dw_d   = rem_dw_q - chunk;
            cur_addr_d = cur_addr_q + {19'd0, chunk, 2'b00};
            state_d    = ST_NEXT;
        end
    end
endmodule

// File: tb/tb_tl_cpl_gen.sv
// Randomized bench for tl_cpl_gen: a completion is modelled as header DWs + data DWs packed four per beat.
`timescale 1ns/1ps
module tb_tl_cpl_gen;
    localparam int TAG_W  = 8;
    localparam int MPS_DW = 32;
`ifdef TL_CPL_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif
    localparam logic [15:0] CPL_ID = 16'hABCD;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [15:0]      completer_id_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [TAG_W-1:0] req_tag_i;
    logic [15:0]      req_id_i;
    logic [31:0]      req_addr_i;
    logic [9:0]       req_len_i;
    logic [2:0]       req_tc_i;
    logic [2:0]       req_attr_i;
    logic             usr_rd_valid_o;
    logic             usr_rd_ready_i;
    logic [31:0]      usr_rd_addr_o;
    logic [10:0]      usr_rd_len_o;
    logic [127:0]     usr_rd_data_i;
    logic             usr_rd_dvalid_i;
    logic             usr_rd_dready_o;
    logic [127:0]     tx_data_o;
    logic             tx_valid_o;
    logic             tx_sop_o;
    logic             tx_eop_o;
    logic             tx_ready_i;

    always #5 clk = ~clk;

    tl_cpl_gen #(.TAG_W(TAG_W), .MPS_DW(MPS_DW)) dut (
        .clk(clk), .rst_n(rst_n), .completer_id_i(completer_id_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_tag_i(req_tag_i),
        .req_id_i(req_id_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .req_tc_i(req_tc_i), .req_attr_i(req_attr_i),
        .usr_rd_valid_o(usr_rd_valid_o), .usr_rd_ready_i(usr_rd_ready_i),
        .usr_rd_addr_o(usr_rd_addr_o), .usr_rd_len_o(usr_rd_len_o),
        .usr_rd_data_i(usr_rd_data_i), .usr_rd_dvalid_i(usr_rd_dvalid_i),
        .usr_rd_dready_o(usr_rd_dready_o), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
        .tx_sop_o(tx_sop_o), .tx_eop_o(tx_eop_o), .tx_ready_i(tx_ready_i)
    );

    typedef struct { logic [127:0] data; logic sop; logic eop; } beat_t;
    typedef struct { logic [31:0] addr; logic [10:0] len; } cmd_t;

    beat_t        exp_q[$];
    cmd_t         cmd_exp_q[$];
    cmd_t         pend_q[$];
    logic [127:0] cap[$];
    int           ubeat, n_ubeats, n_cmds;
    int           total, bad;
    int           txr_mode, gap_pct, rdy_pct;
    bit           req_taken, dv_taken, acc_prev, stall_prev, eop_final;
    int           eop_age;
    logic [127:0] stall_data;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Contents of user memory at a DW address; odd multiplier keeps every DW distinct.
    function automatic logic [31:0] mem_dw(input logic [31:0] dwa);
        return (dwa * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
    endfunction

    function automatic logic [127:0] make_beat(input cmd_t c, input int k);
        logic [127:0] d;
        for (int l = 0; l < 4; l++) begin
            if (4 * k + l < int'(c.len)) d[32*l +: 32] = mem_dw((c.addr >> 2) + 32'(4 * k + l));
            else                          d[32*l +: 32] = $urandom();
        end
        return d;
    endfunction

    task automatic build_expected(input logic [31:0] addr, input logic [9:0] len,
                                  input logic [7:0] tag, input logic [15:0] id,
                                  input logic [2:0] tc, input logic [2:0] attr);
        int          rem, room, c, nb;
        logic [31:0] a;
        logic [31:0] dws[$];
        logic [10:0] cl;
        logic [11:0] bc;
        cmd_t        cm;
        beat_t       bt;
        rem = (len == 10'd0) ? 1024 : int'(len);
        a   = {addr[31:2], 2'b00};
        while (rem > 0) begin
            room = MPS_DW - int'((a >> 2) % 32'(MPS_DW));
            c    = (SPLIT && room < rem) ? room : rem;
            cl   = c[10:0];
            bc   = 12'(rem * 4);
            dws.delete();
            dws.push_back({3'b010, 5'b01010, 1'b0, tc, 1'b0, attr[2], 4'b0, attr[1:0], 2'b0, cl[9:0]});
            dws.push_back({CPL_ID, 4'b0000, bc});
            dws.push_back({id, tag, 1'b0, a[6:0]});
            for (int i = 0; i < c; i++) dws.push_back(mem_dw((a >> 2) + 32'(i)));
            cm.addr = a;
            cm.len  = cl;
            cmd_exp_q.push_back(cm);
            nb = (dws.size() + 3) / 4;
            for (int b = 0; b < nb; b++) begin
                bt.data = '0;
                for (int l = 0; l < 4; l++)
                    if (4 * b + l < dws.size()) bt.data[32*l +: 32] = dws[4*b+l];
                bt.sop = (b == 0);
                bt.eop = (b == nb - 1);
                exp_q.push_back(bt);
            end
            rem -= c;
            a   += 32'(c * 4);
        end
    endtask

    // One clock cycle: entered at posedge+1, drives inputs, checks at posedge+4, returns at next posedge+1.
    task automatic cycle();
        beat_t e;
        cmd_t  c;
        if (req_taken) begin req_valid_i = 1'b0; req_taken = 1'b0; end
        if (dv_taken)  begin usr_rd_dvalid_i = 1'b0; dv_taken = 1'b0; end
        case (txr_mode)
            0:       tx_ready_i = 1'b1;
            1:       tx_ready_i = ~tx_ready_i;
            default: tx_ready_i = ($urandom_range(99) < 60);
        endcase
        usr_rd_ready_i = ($urandom_range(99) < 32'(rdy_pct));
        if (pend_q.size() > 0 && !usr_rd_dvalid_i && $urandom_range(99) >= 32'(gap_pct)) begin
            usr_rd_dvalid_i = 1'b1;
            usr_rd_data_i   = make_beat(pend_q[0], ubeat);
        end
        #3;
        if (acc_prev) chki("rd_valid_after_accept", int'(usr_rd_valid_o), 1);
        acc_prev = 1'b0;
        if (stall_prev) begin
            chki("hold_valid", int'(tx_valid_o), 1);
            chk("hold_data", tx_data_o, stall_data);
        end
        if (eop_age == 2) begin
            if (eop_final) chki("ready_after_eop", int'(req_ready_o), 1);
            else           chki("reissue_after_gap", int'(usr_rd_valid_o), 1);
            eop_age = 0;
        end else if (eop_age == 1) begin
            chki("gap_cycle_quiet", int'({req_ready_o, usr_rd_valid_o, tx_valid_o}), 0);
            eop_age = 2;
        end
        if (req_valid_i && req_ready_o) begin
            build_expected(req_addr_i, req_len_i, req_tag_i, req_id_i, req_tc_i, req_attr_i);
            req_taken = 1'b1;
            acc_prev  = 1'b1;
        end
        if (usr_rd_valid_o && usr_rd_ready_i) begin
            if (cmd_exp_q.size() == 0) begin
                chki("cmd_unexpected", 1, 0);
            end else begin
                c = cmd_exp_q.pop_front();
                chk("cmd_addr", 128'(usr_rd_addr_o), 128'(c.addr));
                chk("cmd_len", 128'(usr_rd_len_o), 128'(c.len));
            end
            c.addr = usr_rd_addr_o;
            c.len  = usr_rd_len_o;
            pend_q.push_back(c);
            n_cmds++;
        end
        if (usr_rd_dvalid_i && usr_rd_dready_o) begin
            n_ubeats++;
            ubeat++;
            dv_taken = 1'b1;
            if (ubeat * 4 >= int'(pend_q[0].len)) begin
                void'(pend_q.pop_front());
                ubeat = 0;
            end
        end
        if (tx_valid_o && tx_ready_i) begin
            cap.push_back(tx_data_o);
            if (exp_q.size() == 0) begin
                chki("tx_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("tx_data", tx_data_o, e.data);
                chki("tx_sop_eop", int'({tx_sop_o, tx_eop_o}), int'({e.sop, e.eop}));
                if (tx_eop_o) begin
                    eop_age   = 1;
                    eop_final = (exp_q.size() == 0);
                end
            end
        end
        stall_prev = tx_valid_o && !tx_ready_i;
        stall_data = tx_data_o;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        cmd_exp_q.delete();
        pend_q.delete();
        ubeat      = 0;
        req_taken  = 1'b0;
        dv_taken   = 1'b0;
        acc_prev   = 1'b0;
        stall_prev = 1'b0;
        eop_age    = 0;
    endtask

    task automatic reset_dut();
        rst_n           = 1'b0;
        req_valid_i     = 1'b0;
        usr_rd_dvalid_i = 1'b0;
        usr_rd_ready_i  = 1'b0;
        tx_ready_i      = 1'b1;
        #1;
        chki("rst_ctrl", int'({tx_valid_o, tx_sop_o, tx_eop_o, usr_rd_valid_o, usr_rd_dready_o, req_ready_o}), 1);
        chk("rst_tx_data", tx_data_o, '0);
        chk("rst_usr_cmd", 128'({usr_rd_addr_o, usr_rd_len_o}), '0);
        clear_model();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [31:0] addr, input logic [9:0] len, input logic [7:0] tag,
                          input logic [15:0] id, input logic [2:0] tc, input logic [2:0] attr);
        int guard;
        guard = 0;
        cap.delete();
        n_ubeats    = 0;
        n_cmds      = 0;
        req_addr_i  = addr;
        req_len_i   = len;
        req_tag_i   = tag;
        req_id_i    = id;
        req_tc_i    = tc;
        req_attr_i  = attr;
        req_valid_i = 1'b1;
        do begin
            cycle();
            guard++;
        end while ((req_valid_i || exp_q.size() > 0 || pend_q.size() > 0 || eop_age != 0) && guard < 6000);
        if (guard >= 6000) begin
            chki("request_timeout", guard, 0);
            reset_dut();
        end
    endtask

    task automatic directed(input int m, input int g);
        txr_mode = m;
        gap_pct  = g;
        rdy_pct  = 100;
    endtask

    initial begin
        int guard;
        total = 0;
        bad   = 0;
        completer_id_i = CPL_ID;
        req_tag_i = '0; req_id_i = '0; req_addr_i = '0; req_len_i = '0; req_tc_i = '0; req_attr_i = '0;
        usr_rd_data_i = '0;
        directed(0, 0);
        reset_dut();

        // Single-DW completion.
        do_req(32'h1000, 10'd1, 8'h05, 16'h0100, 3'd0, 3'd0);
        chki("t1_beats", cap.size(), 1);
        chk("t1_beat0", cap[0], {mem_dw(32'h400), 32'h0100_0500, 32'hABCD_0004, 32'h4A00_0001});

        // Eight DWs at an unaligned-to-beat DW address; tc/attr placement pinned.
        do_req(32'h2004, 10'd8, 8'h11, 16'h0200, 3'd5, 3'b101);
        chki("t2_cmds", n_cmds, 1);
        chki("t2_ubeats", n_ubeats, 2);
        chki("t2_beats", cap.size(), 3);
        chk("t2_hdr", 128'(cap[0][95:0]), 128'({32'h0200_1104, 32'hABCD_0020, 32'h4A54_1008}));
        chk("t2_beat1", cap[1], {mem_dw(32'h805), mem_dw(32'h804), mem_dw(32'h803), mem_dw(32'h802)});
        chk("t2_drain", cap[2], {32'h0, mem_dw(32'h808), mem_dw(32'h807), mem_dw(32'h806)});

        // Forty DWs crossing a 32-DW boundary.
        do_req(32'h3040, 10'd40, 8'h22, 16'h0300, 3'd0, 3'd0);
`ifdef TL_CPL_SPLIT_EN
        chki("t3_cmds", n_cmds, 2);
        chk("t3_hdr1", 128'(cap[0][95:0]), 128'({32'h0300_2240, 32'hABCD_00A0, 32'h4A00_0010}));
        chk("t3_hdr2", 128'(cap[5][95:0]), 128'({32'h0300_2200, 32'hABCD_0060, 32'h4A00_0018}));
`else
        chki("t3_cmds", n_cmds, 1);
        chki("t3_beats", cap.size(), 11);
        chk("t3_hdr", 128'(cap[0][95:0]), 128'({32'h0300_2240, 32'hABCD_00A0, 32'h4A00_0028}));
`endif

        // Six DWs with TX ready toggling and gapped user data.
        directed(1, 40);
        do_req(32'h4010, 10'd6, 8'h33, 16'h0400, 3'd1, 3'd2);
        chki("t4_beats", cap.size(), 3);

        // Length 0 means 1024 DWs.
        directed(0, 0);
        do_req(32'h0, 10'd0, 8'h44, 16'h0500, 3'd0, 3'd0);
        chki("t5_ubeats", n_ubeats, 256);
`ifdef TL_CPL_SPLIT_EN
        chki("t5_cmds", n_cmds, 32);
`else
        chki("t5_beats", cap.size(), 257);
        chk("t5_hdr", 128'(cap[0][63:0]), 128'({32'hABCD_0000, 32'h4A00_0000}));
        chk("t5_last", cap[256], {32'h0, mem_dw(32'd1023), mem_dw(32'd1022), mem_dw(32'd1021)});
`endif

        // Reset in the middle of a 16-DW completion, then a clean single-DW request.
        cap.delete();
        req_addr_i = 32'h5000; req_len_i = 10'd16; req_tag_i = 8'h55; req_id_i = 16'h0600;
        req_tc_i = 3'd0; req_attr_i = 3'd0;
        req_valid_i = 1'b1;
        guard = 0;
        while (cap.size() < 2 && guard < 100) begin
            cycle();
            guard++;
        end
        chki("t6_reached_data", cap.size(), 2);
        reset_dut();
        do_req(32'h6008, 10'd1, 8'h66, 16'h0700, 3'd0, 3'd0);
        chki("t6_beats", cap.size(), 1);
        chk("t6_beat0", cap[0], {mem_dw(32'h1802), 32'h0700_6608, 32'hABCD_0004, 32'h4A00_0001});

        for (int n = 0; n < 40; n++) begin
            txr_mode = $urandom_range(2);
            gap_pct  = $urandom_range(50);
            rdy_pct  = $urandom_range(30, 100);
            do_req($urandom(), 10'($urandom_range(1, 96)), 8'($urandom()), 16'($urandom()),
                   3'($urandom()), 3'($urandom()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
